irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt sequencer for the single-cycle MIPS core; drives the IRQ input of the instruction decoder/control unit.
- Edge-detects and latches up to N_SRC peripheral interrupt requests (timer, UART, etc.), applies a software-programmable mask and fixed priority, and issues a one-cycle IRQ only while the core runs in user mode (PC[31]=0).
- Tracks entry to and exit from the kernel handler, so only one interrupt is delivered per handler invocation.

Parameters:
- N_SRC, 4, number of interrupt sources; 1..8.
- CAUSE_W, 2, width of the cause index; 2^CAUSE_W >= N_SRC.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- src_req  input  N_SRC  raw level requests from peripherals, synchronous to clk.
- kernel_mode  input  1  PC[31] of the core; 1 = handler/kernel running.
- cfg_we  input  1  configuration write strobe, one cycle.
- cfg_addr  input  1  0 = mask register, 1 = pending-clear (write-1-to-clear).
- cfg_wdata  input  N_SRC  configuration write data.
- IRQ  output  1  interrupt request to control unit, registered.
- irq_cause  output  CAUSE_W  index of the source delivered by the last IRQ.
- irq_ack  output  N_SRC  one-hot pulse to the serviced peripheral, coincident with IRQ.
- mask_q  output  N_SRC  current mask; 1 = enabled.
- pending_q  output  N_SRC  current pending bits.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous): IRQ=0, irq_cause=0, irq_ack=0, mask_q=0 (all disabled), pending_q=0, edge-detect history=0, state=IDLE, busy=0. Reset mid-service aborts to IDLE; pending requests are discarded.
- Edge detect: prev <= src_req each cycle; rise = src_req & ~prev. Each rise bit sets pending_q[i] next cycle, regardless of mask. Holding src_req high produces no further rises.
- Pending clear sources:
  - cfg write with cfg_addr=1 clears bits where cfg_wdata=1.
  - The TAKEN state clears the delivered bit.
  - Set beats clear: a rise in the same cycle as any clear leaves the bit set.
- Mask: cfg write with cfg_addr=0 loads mask_q next cycle. Writes are accepted in every state.
- eligible = |(pending_q & mask_q) & ~kernel_mode. winner = lowest index i with pending_q[i]&mask_q[i].
- State machine, all transitions on rising clk:
  - IDLE: if eligible, go to TAKEN; register IRQ=1, irq_cause=winner, irq_ack[winner]=1, and clear pending_q[winner] in the same edge. Otherwise stay.
  - TAKEN: one cycle, IRQ and irq_ack high. Next edge: IRQ=0, irq_ack=0, go to ENTER. Latency from src_req rise to IRQ high is 2 cycles (pending set, then IRQ registered).
  - ENTER: wait for kernel_mode=1, then go to SERVICE. A mask write arriving during TAKEN/ENTER does not cancel delivery.
  - SERVICE: wait for kernel_mode=0 (handler return via jr $26), then go to IDLE. A new request may be delivered no earlier than the cycle after IDLE is re-entered.
- irq_cause holds its value until the next delivery.
- Only one IRQ per handler invocation. Requests arriving during TAKEN/ENTER/SERVICE stay pending and are delivered afterwards in priority order.
- A source masked after pending stays pending, is not delivered, and is delivered once unmasked (if still pending).
- All-masked or no-pending: IRQ never asserts; state remains IDLE.

Test Plan:
- Reset, then mask=4'b1111, pulse src_req[2] at cycle 10 with kernel_mode=0 -> pending_q[2]=1 at cycle 11; IRQ=1, irq_cause=2, irq_ack=4'b0100 at cycle 12 for exactly 1 cycle; pending_q=0; busy=1.
- src_req[1] and src_req[3] rise in the same cycle, mask=4'b1111 -> first IRQ has cause=1. Drive kernel_mode 1 for 5 cycles, then 0 -> second IRQ with cause=3 after IDLE is re-entered; never two IRQs within one kernel window.
- mask=4'b0000, pulse src_req[0] -> pending_q=4'b0001, no IRQ for 20 cycles. Write mask=4'b0001 -> IRQ with cause=0 two cycles after the write.
- kernel_mode=1 held, src_req[0] pulses -> no IRQ while kernel_mode=1. Drop kernel_mode -> IRQ within 2 cycles.
- Pending-clear write of 4'b0010 in the same cycle as a new rise on src_req[1] -> pending_q[1] stays 1. Clear with no rise -> bit 0.
- Assert reset=0 while in SERVICE with pending_q=4'b1000 -> immediately IRQ=0, pending_q=0, mask_q=0, busy=0. After release, no IRQ.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: edge-detected, maskable, fixed-priority interrupt sequencer
// delivering one IRQ per kernel handler invocation.
module irq_controller #(
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_req,
    input  logic               kernel_mode,
    input  logic               cfg_we,
    input  logic               cfg_addr,
    input  logic [N_SRC-1:0]   cfg_wdata,
    output logic               IRQ,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [N_SRC-1:0]   irq_ack,
    output logic [N_SRC-1:0]   mask_q,
    output logic [N_SRC-1:0]   pending_q,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, TAKEN, ENTER, SERVICE} state_t;
    state_t r_state, w_state_nxt;
    logic [N_SRC-1:0]   r_prev, r_mask, r_pend, r_ack;
    logic [N_SRC-1:0]   w_rise, w_hit, w_take, w_clr, w_pend_nxt;
    logic [CAUSE_W-1:0] r_cause, w_winner;
    logic               r_irq, w_eligible, w_fire;
    assign w_rise     = src_req & ~r_prev;
    assign w_hit      = r_pend & r_mask;
    assign w_eligible = |w_hit & ~kernel_mode;
    assign w_fire     = (r_state == IDLE) && w_eligible;
    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (w_hit[i]) w_winner = CAUSE_W'(i);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_eligible  ? TAKEN   : IDLE;
            TAKEN:   w_state_nxt = ENTER;
            ENTER:   w_state_nxt = kernel_mode ? SERVICE : ENTER;
            SERVICE: w_state_nxt = kernel_mode ? SERVICE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    // A new rise wins over any clear landing on the same bit
    always_comb begin
        w_take     = w_fire ? (N_SRC'(1) << w_winner) : '0;
        w_clr      = (cfg_we && cfg_addr) ? cfg_wdata : '0;
        w_pend_nxt = (r_pend & ~w_take & ~w_clr) | w_rise;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_prev  <= '0;
            r_mask  <= '0;
            r_pend  <= '0;
            r_ack   <= '0;
            r_irq   <= 1'b0;
            r_cause <= '0;
        end else begin
            r_prev  <= src_req;
            r_mask  <= (cfg_we && !cfg_addr) ? cfg_wdata : r_mask;
            r_pend  <= w_pend_nxt;
            r_ack   <= w_take;
            r_irq   <= w_fire;
            r_cause <= w_fire ? w_winner : r_cause;
        end
    assign IRQ       = r_irq;
    assign irq_cause = r_cause;
    assign irq_ack   = r_ack;
    assign mask_q    = r_mask;
    assign pending_q = r_pend;
    assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scoreboard bench; expected deliveries are queued when the
// stimulus is driven and popped whenever the DUT raises IRQ.
module tb_irq_controller;
    logic       clk = 0, reset = 0, kernel_mode = 0, cfg_we = 0, cfg_addr = 0;
    logic [3:0] src_req = 0, cfg_wdata = 0;
    logic       IRQ, busy;
    logic [1:0] irq_cause;
    logic [3:0] irq_ack, mask_q, pending_q;
    typedef struct {logic [1:0] cause; logic [3:0] ack;} exp_t;
    exp_t sb[$];
    int n_checks = 0, n_fail = 0;

    irq_controller #(.N_SRC(4), .CAUSE_W(2)) dut (
        .clk(clk), .reset(reset), .src_req(src_req), .kernel_mode(kernel_mode),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .IRQ(IRQ), .irq_cause(irq_cause), .irq_ack(irq_ack),
        .mask_q(mask_q), .pending_q(pending_q), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cfg(input logic addr, input logic [3:0] data);
        cfg_we = 1; cfg_addr = addr; cfg_wdata = data;
        tick(1);
        cfg_we = 0; cfg_wdata = 0;
    endtask

    task automatic expect_irq(input logic [1:0] cause);
        exp_t e;
        e.cause = cause;
        e.ack   = 4'b0001 << cause;
        sb.push_back(e);
    endtask

    task automatic service(input int k);
        kernel_mode = 1;
        tick(k);
        kernel_mode = 0;
        tick(1);
    endtask

    always @(posedge clk) begin
        #1;
        if (reset && IRQ) begin
            if (sb.size() == 0) check("unexpected_irq", {30'd0, irq_cause}, 32'hFFFF);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("irq_cause", irq_cause, e.cause);
                check("irq_ack", irq_ack, e.ack);
            end
        end
    end

    initial begin
        tick(3);
        check("rst_irq", IRQ, 0);
        check("rst_mask", mask_q, 0);
        check("rst_pend", pending_q, 0);
        check("rst_busy", busy, 0);
        reset = 1;
        tick(1);
        // single source, latency 2
        cfg(0, 4'hF);
        check("mask_load", mask_q, 4'hF);
        src_req = 4'b0100;
        tick(1);
        src_req = 0;
        check("t1_pend", pending_q, 4'b0100);
        check("t1_noirq", IRQ, 0);
        expect_irq(2);
        tick(1);
        check("t1_irq", IRQ, 1);
        check("t1_pend_clr", pending_q, 0);
        check("t1_busy", busy, 1);
        tick(1);
        check("t1_irq_1cyc", IRQ, 0);
        check("t1_enter_busy", busy, 1);
        service(2);
        check("t1_idle", busy, 0);
        check("t1_cause_hold", irq_cause, 2);
        // priority and one IRQ per kernel window
        src_req = 4'b1010;
        tick(1);
        src_req = 0;
        check("t2_pend", pending_q, 4'b1010);
        expect_irq(1);
        tick(1);
        check("t2_irq1", IRQ, 1);
        check("t2_pend_left", pending_q, 4'b1000);
        tick(1);
        kernel_mode = 1;
        tick(5);
        check("t2_window_pend", pending_q, 4'b1000);
        expect_irq(3);
        kernel_mode = 0;
        tick(1);
        check("t2_idle_noirq", IRQ, 0);
        tick(1);
        check("t2_irq2", IRQ, 1);
        tick(1);
        service(1);
        // masked pending, delivered once unmasked
        cfg(0, 4'h0);
        src_req = 4'b0001;
        tick(1);
        src_req = 0;
        check("t3_pend", pending_q, 4'b0001);
        tick(20);
        check("t3_masked_noirq", IRQ, 0);
        check("t3_masked_idle", busy, 0);
        expect_irq(0);
        cfg(0, 4'h1);
        check("t3_wait", IRQ, 0);
        tick(1);
        check("t3_irq", IRQ, 1);
        tick(1);
        service(1);
        // kernel mode blocks delivery
        kernel_mode = 1;
        src_req = 4'b0001;
        tick(1);
        src_req = 0;
        tick(5);
        check("t4_pend", pending_q, 4'b0001);
        check("t4_kernel_noirq", IRQ, 0);
        expect_irq(0);
        kernel_mode = 0;
        tick(1);
        check("t4_irq", IRQ, 1);
        tick(1);
        service(1);
        // set beats clear
        cfg(0, 4'h0);
        src_req = 4'b0010;
        tick(1);
        src_req = 0;
        tick(1);
        check("t5_pend", pending_q, 4'b0010);
        src_req = 4'b0010;
        cfg(1, 4'b0010);
        src_req = 0;
        check("t5_set_wins", pending_q, 4'b0010);
        cfg(1, 4'b0010);
        check("t5_clear", pending_q, 0);
        // async reset in SERVICE
        cfg(0, 4'hF);
        src_req = 4'b0001;
        tick(1);
        src_req = 0;
        expect_irq(0);
        tick(2);
        kernel_mode = 1;
        tick(1);
        src_req = 4'b1000;
        tick(1);
        src_req = 0;
        check("t6_service_busy", busy, 1);
        check("t6_pend", pending_q, 4'b1000);
        #2 reset = 0;
        #1;
        check("t6_rst_irq", IRQ, 0);
        check("t6_rst_pend", pending_q, 0);
        check("t6_rst_mask", mask_q, 0);
        check("t6_rst_busy", busy, 0);
        tick(2);
        reset = 1;
        kernel_mode = 0;
        tick(10);
        check("t6_post_noirq", IRQ, 0);
        check("t6_post_idle", busy, 0);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
